// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore sequencer and ALU decoder for the multicycle RISC-V datapath
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state_q;
  state_t     state_d;
  state_t     cur;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // While reset is held the outputs already look like FETCH, minus the write enables.
  assign cur   = rst ? state_q : S_FETCH;
  assign state = cur;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_update   = 1'b0;
    branch      = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_write_s = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write  = rst & (pc_update | (branch & zero));
  assign ir_write  = rst & ir_write_s;
  assign mem_write = rst & mem_write_s;
  assign reg_write = rst & reg_write_s;

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
    logic [3:0] state;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic [3:0] state;

  ctl_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .reg_write(reg_write), .state(state)
  );

  always #5 clk = ~clk;

  // Instruction-level model: each opcode class is a fixed list of visited states.
  function automatic int instr_len(logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int instr_state(logic [6:0] o, int k);
    int s[5];
    case (o)
      7'b0000011: s = '{0, 1, 2, 3, 4};
      7'b0100011: s = '{0, 1, 2, 5, 0};
      7'b0110011: s = '{0, 1, 6, 8, 0};
      7'b0010011: s = '{0, 1, 7, 8, 0};
      7'b1100011: s = '{0, 1, 9, 0, 0};
      7'b1101111: s = '{0, 1, 10, 8, 0};
      default:    s = '{0, 1, 0, 0, 0};
    endcase
    return s[k];
  endfunction

  function automatic logic [2:0] alu_fn(logic [1:0] aop, logic [6:0] o, logic [2:0] f3, logic f7);
    if (aop == 2'b00) return 3'b000;
    if (aop == 2'b01) return 3'b001;
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctl_t model_out(int st, logic [6:0] o, logic [2:0] f3, logic f7, logic z, logic r);
    ctl_t c;
    logic [1:0] aop;
    logic pcu, br;
    c = '0;
    aop = 2'b00;
    pcu = 1'b0;
    br = 1'b0;
    if (!r) begin
      c.result_src = 2'b10;
      c.alu_src_b = 2'b10;
      return c;
    end
    c.state = st[3:0];
    case (st)
      0:  begin c.ir_write = 1; c.alu_src_b = 2'b10; c.result_src = 2'b10; pcu = 1; end
      1:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      2:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      3:  c.adr_src = 1;
      4:  begin c.result_src = 2'b01; c.reg_write = 1; end
      5:  begin c.adr_src = 1; c.mem_write = 1; end
      6:  begin c.alu_src_a = 2'b10; aop = 2'b10; end
      7:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; aop = 2'b10; end
      8:  c.reg_write = 1;
      9:  begin c.alu_src_a = 2'b10; aop = 2'b01; br = 1; end
      10: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; pcu = 1; end
      default: ;
    endcase
    c.pc_write = pcu | (br & z);
    c.alu_control = alu_fn(aop, o, f3, f7);
    return c;
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      zero = 1'($urandom_range(0, 1));
      exp_q.push_back(model_out(0, op, funct3, funct7b5, zero, 1'b0));
    end
  endtask

  // zmode: 0/1 force zero, 2 randomises it every cycle; ncyc < length aborts early.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      op = o;
      funct3 = f3;
      funct7b5 = f7;
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      exp_q.push_back(model_out(instr_state(o, k), o, f3, f7, zero, 1'b1));
    end
  endtask

  task automatic run_full(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zmode);
    run_instr(o, f3, f7, zmode, instr_len(o));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ctl_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
             alu_control, reg_write, state};
        checks++;
        if (a === e) passed++;
        else $display("FAIL outputs cyc=%0d op=%b f3=%b f7=%b zero=%b rst=%b got=%h exp=%h (state got %0d exp %0d)",
                      cyc, op, funct3, funct7b5, zero, rst, a, e, a.state, e.state);
      end
    end
  end

  initial begin
    logic [6:0] ops[7];
    logic [6:0] o;
    int len, drain;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1111111};

    do_reset(2);
    // Reach MEMWRITE then hold reset for three cycles.
    run_instr(7'b0100011, 3'b010, 1'b0, 2, 4);
    do_reset(3);
    run_full(7'b0000011, 3'b010, 1'b0, 2);
    run_full(7'b0110011, 3'b000, 1'b1, 2);
    run_full(7'b0110011, 3'b000, 1'b0, 2);
    run_full(7'b0110011, 3'b111, 1'b0, 2);
    run_full(7'b0110011, 3'b010, 1'b0, 2);
    run_full(7'b0110011, 3'b110, 1'b1, 2);
    run_full(7'b0010011, 3'b000, 1'b1, 2);
    run_full(7'b1100011, 3'b000, 1'b0, 1);
    run_full(7'b1100011, 3'b000, 1'b0, 0);
    run_full(7'b0100011, 3'b010, 1'b0, 2);
    run_full(7'b1101111, 3'b000, 1'b0, 2);
    run_full(7'b1111111, 3'b000, 1'b0, 2);
    // Abort a load in MEMREAD; MEMWB must never appear.
    run_instr(7'b0000011, 3'b010, 1'b0, 2, 4);
    do_reset(1);
    run_full(7'b0110011, 3'b000, 1'b1, 2);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) o = 7'($urandom);
      else o = ops[$urandom_range(0, 6)];
      len = instr_len(o);
      if ($urandom_range(0, 9) == 0) begin
        run_instr(o, 3'($urandom), 1'($urandom), 2, $urandom_range(1, len - 1));
        do_reset($urandom_range(1, 3));
      end else begin
        run_full(o, 3'($urandom), 1'($urandom), 2);
      end
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain remaining=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
